// File: rtl/sprite_reg_writer.sv
// Buffers sprite-register updates in a FIFO and drains them as Avalon-MM writes
// only after the falling edge of vertical sync, so positions change between frames.
module sprite_reg_writer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_W        = 9,
    parameter int MAX_PER_FRAME = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [ADDR_W-1:0]           upd_addr,
    input  logic [7:0]                  upd_data,
    input  logic                        en,
    input  logic                        vga_vs,
    output logic [ADDR_W-1:0]           avm_address,
    output logic [31:0]                 avm_writedata,
    output logic                        avm_write,
    output logic                        avm_chipselect,
    input  logic                        avm_waitrequest,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clear_overflow,
    output logic                        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(MAX_PER_FRAME + 1);

    typedef logic [ADDR_W+7:0] entry_t;
    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_d;
    entry_t            mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_inc;
    logic [CW-1:0]     count, count_d;
    logic [BW-1:0]     beat_cnt, beat_d, beat_inc;
    logic              vs_q, trig, push, pop, more;
    logic              write_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d, wdata_q;
    entry_t            head, next_head;

    assign upd_ready      = (count != CW'(FIFO_DEPTH));
    assign push           = upd_valid && upd_ready;
    assign pop            = avm_write && !avm_waitrequest;
    assign count_d        = count + CW'(push) - CW'(pop);
    assign trig           = vs_q && !vga_vs;
    assign rd_ptr_inc     = rd_ptr + PW'(1);
    assign beat_inc       = beat_cnt + BW'(1);
    assign more           = (count_d != '0) && (beat_inc < BW'(MAX_PER_FRAME));
    assign head           = mem[rd_ptr];
    // With one entry left, the successor is the word being pushed this cycle and is not yet in mem.
    assign next_head      = (count == CW'(1) && push) ? {upd_addr, upd_data} : mem[rd_ptr_inc];

    assign avm_writedata  = {24'b0, wdata_q};
    assign avm_chipselect = avm_write;
    assign fifo_count     = count;
    assign busy           = (state == WRITE);

    always_comb begin
        state_d = state;
        write_d = avm_write;
        addr_d  = avm_address;
        data_d  = wdata_q;
        beat_d  = beat_cnt;
        case (state)
            IDLE: begin
                if (trig && en && count != '0) begin
                    state_d          = WRITE;
                    write_d          = 1'b1;
                    {addr_d, data_d} = head;
                    beat_d           = '0;
                end
            end
            WRITE: begin
                if (pop) begin
                    beat_d = beat_inc;
                    if (more) begin
                        {addr_d, data_d} = next_head;
                    end else begin
                        write_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            vs_q        <= 1'b1;
            avm_write   <= 1'b0;
            avm_address <= '0;
            wdata_q     <= '0;
            beat_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_d;
            vs_q        <= vga_vs;
            avm_write   <= write_d;
            avm_address <= addr_d;
            wdata_q     <= data_d;
            beat_cnt    <= beat_d;
            count       <= count_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            if (clear_overflow)
                overflow <= 1'b0;
            else if (upd_valid && !upd_ready)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {upd_addr, upd_data};
    end

endmodule
